// File: rtl/mic_m_arb2.sv
// Two-master MIC arbiter: grants one master for a full request/response
// transaction and passes its channels through combinationally.
module mic_m_arb2 #(
  parameter bit RR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M0_O_TVALID,
  input  logic [63:0] M0_O_TDATA,
  input  logic        M0_O_TLAST,
  output logic        M0_O_TREADY,
  output logic        M0_I_TVALID,
  output logic [63:0] M0_I_TDATA,
  output logic        M0_I_TLAST,
  input  logic        M0_I_TREADY,
  input  logic        M1_O_TVALID,
  input  logic [63:0] M1_O_TDATA,
  input  logic        M1_O_TLAST,
  output logic        M1_O_TREADY,
  output logic        M1_I_TVALID,
  output logic [63:0] M1_I_TDATA,
  output logic        M1_I_TLAST,
  input  logic        M1_I_TREADY,
  output logic        S_O_TVALID,
  output logic [63:0] S_O_TDATA,
  output logic        S_O_TLAST,
  input  logic        S_O_TREADY,
  input  logic        S_I_TVALID,
  input  logic [63:0] S_I_TDATA,
  input  logic        S_I_TLAST,
  output logic        S_I_TREADY,
  output logic        grant,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t      r_state;
  logic        r_grant;
  logic        r_last;
  logic        r_busy;

  logic        w_in_req;
  logic        w_in_resp;
  logic        w_pick;
  logic [1:0]  w_o_tvalid;
  logic [1:0]  w_o_tlast;
  logic [1:0]  w_i_tready;
  logic [1:0]  w_sel;
  logic [1:0]  w_o_tready;
  logic [1:0]  w_i_tvalid;
  logic [1:0]  w_i_tlast;
  logic [63:0] w_o_tdata [2];
  logic [63:0] w_i_tdata [2];

  assign w_in_req   = (r_state == REQ);
  assign w_in_resp  = (r_state == RESP);
  assign w_o_tvalid = {M1_O_TVALID, M0_O_TVALID};
  assign w_o_tlast  = {M1_O_TLAST, M0_O_TLAST};
  assign w_i_tready = {M1_I_TREADY, M0_I_TREADY};
  assign w_o_tdata[0] = M0_O_TDATA;
  assign w_o_tdata[1] = M1_O_TDATA;

  // On a tie, round-robin favours the master not granted last time.
  assign w_pick = (w_o_tvalid == 2'b11) ? (RR ? ~r_last : 1'b0) : w_o_tvalid[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign w_sel[gi]      = (r_grant == (gi == 1));
      assign w_o_tready[gi] = w_in_req & w_sel[gi] & S_O_TREADY;
      assign w_i_tvalid[gi] = w_in_resp & w_sel[gi] & S_I_TVALID;
      assign w_i_tlast[gi]  = w_in_resp & w_sel[gi] & S_I_TLAST;
      assign w_i_tdata[gi]  = (w_in_resp & w_sel[gi]) ? S_I_TDATA : 64'd0;
    end
  endgenerate

  assign M0_O_TREADY = w_o_tready[0];
  assign M1_O_TREADY = w_o_tready[1];
  assign M0_I_TVALID = w_i_tvalid[0];
  assign M1_I_TVALID = w_i_tvalid[1];
  assign M0_I_TLAST  = w_i_tlast[0];
  assign M1_I_TLAST  = w_i_tlast[1];
  assign M0_I_TDATA  = w_i_tdata[0];
  assign M1_I_TDATA  = w_i_tdata[1];

  assign S_O_TVALID = w_in_req & w_o_tvalid[r_grant];
  assign S_O_TLAST  = w_in_req & w_o_tlast[r_grant];
  assign S_O_TDATA  = w_in_req ? w_o_tdata[r_grant] : 64'd0;
  assign S_I_TREADY = w_in_resp & w_i_tready[r_grant];

  assign grant = r_grant;
  assign busy  = r_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_o_tvalid) begin
            r_grant <= w_pick;
            r_last  <= w_pick;
            r_busy  <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (S_O_TVALID && S_O_TREADY && S_O_TLAST) begin
            r_state <= RESP;
          end
        end
        RESP: begin
          if (S_I_TVALID && S_I_TREADY && S_I_TLAST) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mic_m_arb2.sv
// Scoreboard bench for mic_m_arb2: one round-robin and one fixed-priority
// instance share stimulus; sel picks which one the monitor observes.
module tb_mic_m_arb2;
  typedef struct { logic [63:0] d; logic l; logic g; } beat_t;
  typedef struct { logic [63:0] d; logic l; int dly; bit early; } resp_t;

  localparam logic [63:0] RR_SO  [8] = '{64'h10, 64'h20, 64'h11, 64'h21, 64'h12, 64'h22, 64'h13, 64'h23};
  localparam logic        RR_G   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [63:0] FP_SO  [8] = '{64'h10, 64'h11, 64'h12, 64'h13, 64'h20, 64'h21, 64'h22, 64'h23};
  localparam logic        FP_G   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  bit          sel;
  logic        M0_O_TVALID, M0_O_TLAST, M0_I_TREADY;
  logic        M1_O_TVALID, M1_O_TLAST, M1_I_TREADY;
  logic [63:0] M0_O_TDATA, M1_O_TDATA, S_I_TDATA;
  logic        S_O_TREADY, S_I_TVALID, S_I_TLAST;

  logic        w_m0_o_tready [2], w_m0_i_tvalid [2], w_m0_i_tlast [2];
  logic        w_m1_o_tready [2], w_m1_i_tvalid [2], w_m1_i_tlast [2];
  logic [63:0] w_m0_i_tdata [2], w_m1_i_tdata [2], w_s_o_tdata [2];
  logic        w_s_o_tvalid [2], w_s_o_tlast [2], w_s_i_tready [2];
  logic        w_grant [2], w_busy [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mic_m_arb2 #(.RR(gi == 0)) dut (
      .clk(clk), .reset(reset),
      .M0_O_TVALID(M0_O_TVALID), .M0_O_TDATA(M0_O_TDATA), .M0_O_TLAST(M0_O_TLAST),
      .M0_O_TREADY(w_m0_o_tready[gi]), .M0_I_TVALID(w_m0_i_tvalid[gi]),
      .M0_I_TDATA(w_m0_i_tdata[gi]), .M0_I_TLAST(w_m0_i_tlast[gi]), .M0_I_TREADY(M0_I_TREADY),
      .M1_O_TVALID(M1_O_TVALID), .M1_O_TDATA(M1_O_TDATA), .M1_O_TLAST(M1_O_TLAST),
      .M1_O_TREADY(w_m1_o_tready[gi]), .M1_I_TVALID(w_m1_i_tvalid[gi]),
      .M1_I_TDATA(w_m1_i_tdata[gi]), .M1_I_TLAST(w_m1_i_tlast[gi]), .M1_I_TREADY(M1_I_TREADY),
      .S_O_TVALID(w_s_o_tvalid[gi]), .S_O_TDATA(w_s_o_tdata[gi]), .S_O_TLAST(w_s_o_tlast[gi]),
      .S_O_TREADY(S_O_TREADY), .S_I_TVALID(S_I_TVALID), .S_I_TDATA(S_I_TDATA),
      .S_I_TLAST(S_I_TLAST), .S_I_TREADY(w_s_i_tready[gi]),
      .grant(w_grant[gi]), .busy(w_busy[gi])
    );
  end

  logic        m0_o_tready, m0_i_tvalid, m1_o_tready, m1_i_tvalid;
  logic        s_o_tvalid, s_o_tlast, s_i_tready, grant, busy;
  logic [63:0] m0_i_tdata, m1_i_tdata, s_o_tdata;
  logic        m0_i_tlast, m1_i_tlast;
  assign m0_o_tready = w_m0_o_tready[sel];
  assign m0_i_tvalid = w_m0_i_tvalid[sel];
  assign m0_i_tdata  = w_m0_i_tdata[sel];
  assign m0_i_tlast  = w_m0_i_tlast[sel];
  assign m1_o_tready = w_m1_o_tready[sel];
  assign m1_i_tvalid = w_m1_i_tvalid[sel];
  assign m1_i_tdata  = w_m1_i_tdata[sel];
  assign m1_i_tlast  = w_m1_i_tlast[sel];
  assign s_o_tvalid  = w_s_o_tvalid[sel];
  assign s_o_tdata   = w_s_o_tdata[sel];
  assign s_o_tlast   = w_s_o_tlast[sel];
  assign s_i_tready  = w_s_i_tready[sel];
  assign grant       = w_grant[sel];
  assign busy        = w_busy[sel];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 64'(act), 64'(exp));
  endtask

  task automatic fail_msg(input string nm, input logic [63:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0h, expected nothing (t=%0t)", nm, act, $time);
  endtask

  // Stimulus sources and scoreboard queues
  beat_t m0_src[$], m1_src[$], exp_so[$], exp_m0[$], exp_m1[$];
  resp_t sl_q[$];
  bit    sor_q[$];
  int    sl_wait = 0;

  bit m0_hs, m1_hs, si_hs;
  int outstanding = 0;
  int cyc = 0, resp_cyc = 0;
  bit resp_seen, in_pkt, post_req, post_resp, gap_check;
  logic p_sov = 1'b0, p_sor = 1'b0, p_sol = 1'b0;
  logic [63:0] p_sod = 64'd0;

  // Drivers: masters, interconnect response side, and S_O backpressure
  always @(posedge clk) begin
    #1;
    if (m0_hs && m0_src.size() != 0) m0_src.delete(0);
    if (m1_hs && m1_src.size() != 0) m1_src.delete(0);
    if (m0_src.size() != 0) begin
      M0_O_TVALID = 1'b1; M0_O_TDATA = m0_src[0].d; M0_O_TLAST = m0_src[0].l;
    end else begin
      M0_O_TVALID = 1'b0; M0_O_TDATA = 64'd0; M0_O_TLAST = 1'b0;
    end
    if (m1_src.size() != 0) begin
      M1_O_TVALID = 1'b1; M1_O_TDATA = m1_src[0].d; M1_O_TLAST = m1_src[0].l;
    end else begin
      M1_O_TVALID = 1'b0; M1_O_TDATA = 64'd0; M1_O_TLAST = 1'b0;
    end
    if (si_hs && sl_q.size() != 0) begin
      sl_q.delete(0);
      sl_wait = 0;
    end
    S_I_TVALID = 1'b0; S_I_TDATA = 64'd0; S_I_TLAST = 1'b0;
    if (sl_q.size() != 0 && (outstanding != 0 || sl_q[0].early)) begin
      if (sl_wait >= sl_q[0].dly) begin
        S_I_TVALID = 1'b1; S_I_TDATA = sl_q[0].d; S_I_TLAST = sl_q[0].l;
      end else begin
        sl_wait++;
      end
    end
    if (sor_q.size() != 0) begin
      S_O_TREADY = sor_q[0];
      sor_q.delete(0);
    end else begin
      S_O_TREADY = 1'b1;
    end
  end

  // Monitor: protocol checks and scoreboard pops
  always @(negedge clk) begin : mon
    beat_t e;
    bit so_hs, mi0_hs, mi1_hs;
    cyc++;
    if (!reset) begin
      p_sov = 1'b0; outstanding = 0; post_req = 0; post_resp = 0; in_pkt = 0;
      m0_hs = 0; m1_hs = 0; si_hs = 0; resp_seen = 0;
    end else begin
      if (post_resp) chk1("busy_after_resp", busy, 1'b0);
      if (post_req)  chk1("busy_in_resp", busy, 1'b1);
      post_req = 0; post_resp = 0;
      if (p_sov && !p_sor) begin
        chk1("hold_valid", s_o_tvalid, 1'b1);
        chk("hold_data", s_o_tdata, p_sod);
        chk1("hold_last", s_o_tlast, p_sol);
      end
      if (outstanding != 0) begin
        chk1("s_o_valid_in_resp", s_o_tvalid, 1'b0);
      end else begin
        chk1("s_i_ready_before_resp", s_i_tready, 1'b0);
        chk1("m0_i_valid_before_resp", m0_i_tvalid, 1'b0);
        chk1("m1_i_valid_before_resp", m1_i_tvalid, 1'b0);
      end
      m0_hs  = M0_O_TVALID && m0_o_tready;
      m1_hs  = M1_O_TVALID && m1_o_tready;
      so_hs  = s_o_tvalid && S_O_TREADY;
      si_hs  = S_I_TVALID && s_i_tready;
      mi0_hs = m0_i_tvalid && M0_I_TREADY;
      mi1_hs = m1_i_tvalid && M1_I_TREADY;
      if (m0_hs || m1_hs || so_hs) chk("o_route", 64'(m0_hs) + 64'(m1_hs), 64'(so_hs));
      if (mi0_hs || mi1_hs || si_hs) chk("i_route", 64'(mi0_hs) + 64'(mi1_hs), 64'(si_hs));
      if (so_hs) begin
        if (exp_so.size() == 0) begin
          fail_msg("so_unexpected", s_o_tdata);
        end else begin
          e = exp_so.pop_front();
          chk("so_data", s_o_tdata, e.d);
          chk1("so_last", s_o_tlast, e.l);
          chk1("so_grant", grant, e.g);
          if (!in_pkt && gap_check && resp_seen) chk("turnaround", 64'(cyc - resp_cyc), 64'd2);
        end
        in_pkt = !s_o_tlast;
        if (s_o_tlast) begin
          outstanding = 1;
          post_req = 1;
        end
      end
      if (m0_i_tvalid && exp_m0.size() == 0) fail_msg("m0_i_unexpected", m0_i_tdata);
      else if (mi0_hs) begin
        e = exp_m0.pop_front();
        chk("m0_i_data", m0_i_tdata, e.d);
        chk1("m0_i_last", m0_i_tlast, e.l);
      end
      if (m1_i_tvalid && exp_m1.size() == 0) fail_msg("m1_i_unexpected", m1_i_tdata);
      else if (mi1_hs) begin
        e = exp_m1.pop_front();
        chk("m1_i_data", m1_i_tdata, e.d);
        chk1("m1_i_last", m1_i_tlast, e.l);
      end
      if (si_hs && S_I_TLAST) begin
        outstanding = 0;
        post_resp = 1;
        resp_cyc = cyc;
        resp_seen = 1;
      end
      p_sov = s_o_tvalid; p_sor = S_O_TREADY; p_sod = s_o_tdata; p_sol = s_o_tlast;
    end
  end

  task automatic push_src(input int m, input logic [63:0] d, input logic l);
    beat_t b;
    b.d = d; b.l = l; b.g = m[0];
    if (m == 0) m0_src.push_back(b); else m1_src.push_back(b);
  endtask

  task automatic push_so(input logic [63:0] d, input logic l, input logic g);
    beat_t b;
    b.d = d; b.l = l; b.g = g;
    exp_so.push_back(b);
  endtask

  task automatic push_resp(input int m, input logic [63:0] d, input int dly, input bit early);
    resp_t r;
    beat_t b;
    r.d = d; r.l = 1'b1; r.dly = dly; r.early = early;
    b.d = d; b.l = 1'b1; b.g = m[0];
    sl_q.push_back(r);
    if (m == 0) exp_m0.push_back(b); else exp_m1.push_back(b);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m0_src.delete(); m1_src.delete(); sl_q.delete(); sor_q.delete();
    exp_so.delete(); exp_m0.delete(); exp_m1.delete();
    sl_wait = 0; gap_check = 0;
    #1;
    chk1("rst_busy_now", busy, 1'b0);
    chk1("rst_s_o_valid_now", s_o_tvalid, 1'b0);
    chk("rst_s_o_data_now", s_o_tdata, 64'd0);
    chk1("rst_m0_o_ready_now", m0_o_tready, 1'b0);
    chk1("rst_m1_i_valid_now", m1_i_tvalid, 1'b0);
    repeat (3) begin
      @(negedge clk); #1;
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_s_o_valid", s_o_tvalid, 1'b0);
      chk1("rst_s_i_ready", s_i_tready, 1'b0);
      chk1("rst_grant", grant, 1'b0);
    end
    #2 reset = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_so.size() != 0 || exp_m0.size() != 0 || exp_m1.size() != 0 ||
            m0_src.size() != 0 || m1_src.size() != 0 || sl_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail_msg("timeout", 64'(n));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0;
    M0_O_TVALID = 0; M0_O_TDATA = 0; M0_O_TLAST = 0; M0_I_TREADY = 1;
    M1_O_TVALID = 0; M1_O_TDATA = 0; M1_O_TLAST = 0; M1_I_TREADY = 1;
    S_O_TREADY = 1; S_I_TVALID = 0; S_I_TDATA = 0; S_I_TLAST = 0;
    #1;
    do_reset();

    // M0 alone, 2-beat request, delayed response
    push_src(0, 64'hA0, 1'b0); push_src(0, 64'hA1, 1'b1);
    push_so(64'hA0, 1'b0, 1'b0); push_so(64'hA1, 1'b1, 1'b0);
    push_resp(0, 64'hB0, 3, 1'b0);
    @(negedge clk); #1;
    chk1("latency_idle_s_o_valid", s_o_tvalid, 1'b0);
    chk1("latency_idle_busy", busy, 1'b0);
    @(negedge clk); #1;
    chk1("latency_req_s_o_valid", s_o_tvalid, 1'b1);
    chk("latency_req_s_o_data", s_o_tdata, 64'hA0);
    chk1("latency_req_busy", busy, 1'b1);
    wait_done(100);

    // Both masters continuously requesting: round-robin, then fixed priority
    for (int t = 0; t < 2; t++) begin
      @(negedge clk); #3;
      sel = (t == 1);
      do_reset();
      gap_check = 1;
      for (int i = 0; i < 4; i++) begin
        push_src(0, 64'h10 + 64'(i), 1'b1);
        push_src(1, 64'h20 + 64'(i), 1'b1);
      end
      for (int i = 0; i < 8; i++) begin
        if (t == 0) begin
          push_so(RR_SO[i], 1'b1, RR_G[i]);
          push_resp(RR_G[i] ? 1 : 0, 64'h30 + 64'(i), 0, 1'b0);
        end else begin
          push_so(FP_SO[i], 1'b1, FP_G[i]);
          push_resp(FP_G[i] ? 1 : 0, 64'h30 + 64'(i), 0, 1'b0);
        end
      end
      wait_done(200);
    end

    // Backpressured 3-beat M1 request with an early response
    @(negedge clk); #3;
    sel = 1'b0;
    do_reset();
    push_src(1, 64'h50, 1'b0); push_src(1, 64'h51, 1'b0); push_src(1, 64'h52, 1'b1);
    push_so(64'h50, 1'b0, 1'b1); push_so(64'h51, 1'b0, 1'b1); push_so(64'h52, 1'b1, 1'b1);
    sor_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    push_resp(1, 64'h60, 0, 1'b1);
    repeat (7) begin
      @(negedge clk); #1;
      if (s_o_tvalid) chk1("m1_ready_mirror", m1_o_tready, S_O_TREADY);
    end
    wait_done(100);

    // Reset asserted between beats of an M0 packet, then normal recovery
    @(negedge clk); #3;
    do_reset();
    push_src(0, 64'h70, 1'b0); push_src(0, 64'h71, 1'b0); push_src(0, 64'h72, 1'b1);
    push_so(64'h70, 1'b0, 1'b0);
    sor_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    #1;
    chk("pre_reset_beat2", s_o_tdata, 64'h71);
    #2 reset = 1'b0;
    #1;
    chk1("midrst_s_o_valid", s_o_tvalid, 1'b0);
    chk("midrst_s_o_data", s_o_tdata, 64'd0);
    chk1("midrst_m0_o_ready", m0_o_tready, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    do_reset();
    push_src(0, 64'h80, 1'b1);
    push_so(64'h80, 1'b1, 1'b0);
    push_resp(0, 64'h90, 0, 1'b0);
    wait_done(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
